regfile_dump_reader: RTL



---
 rtl/regfile_dump_reader_pkg.sv | 19 +
 rtl/regfile_dump_reader_word_serializer.sv | 37 +++
 rtl/regfile_dump_reader.sv | 104 ++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM encodings and byte sizing.
package regfile_dump_reader_pkg;

  localparam int NB_BYTE_DEF    = 8;
  localparam int LEN_DEF        = 32;
  localparam int BYTES_PER_WORD = LEN_DEF / NB_BYTE_DEF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WAIT = 3'd2,
    ST_CAPT = 3'd3,
    ST_SEND = 3'd4,
    ST_TXW  = 3'd5,
    ST_NEXT = 3'd6,
    ST_DONE = 3'd7
  } state_t;

endpackage

// File: rtl/regfile_dump_reader_word_serializer.sv
// Holds one captured register word and hands it out MSB byte first.
module word_serializer #(
  parameter int LEN     = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [LEN-1:0]     i_word,
  input  logic               i_shift,
  output logic [NB_BYTE-1:0] o_byte,
  output logic               o_last
);

  localparam int BPW    = LEN / NB_BYTE;
  localparam int NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;

  logic [LEN-1:0]    capt_q;
  logic [NB_CNT-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      capt_q <= '0;
      cnt_q  <= '0;
    end else if (i_load) begin
      capt_q <= i_word;
      cnt_q  <= '0;
    end else if (i_shift) begin
      capt_q <= capt_q << NB_BYTE;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign o_byte = capt_q[LEN-1 -: NB_BYTE];
  assign o_last = (cnt_q == NB_CNT'(BPW - 1));

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks every register through the read port and streams each word to the debug UART TX.
//
// state | meaning
// IDLE  | waiting for i_start
// ADDR  | present the address counter to the register file
// WAIT  | register file read latency
// CAPT  | capture read data into the serializer
// SEND  | one-cycle o_tx_start with the current byte
// TXW   | wait for i_tx_done, then shift to the next byte
// NEXT  | advance the address or finish
// DONE  | one-cycle o_done, return to IDLE
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int LEN     = LEN_DEF,
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_BYTE = NB_BYTE_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic [NB_ADDR-1:0] o_read_addr,
  input  logic [LEN-1:0]     i_read_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  state_t             state_q, state_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic               ser_load, ser_shift, ser_last;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_ADDR;
          addr_d  = '0;
        end
      end
      ST_ADDR: state_d = ST_WAIT;
      ST_WAIT: state_d = ST_CAPT;
      ST_CAPT: begin
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: state_d = ST_TXW;
      ST_TXW: begin
        // Only this state consumes i_tx_done, so at most one byte is in flight.
        if (i_tx_done) begin
          ser_shift = 1'b1;
          state_d   = ser_last ? ST_NEXT : ST_SEND;
        end
      end
      ST_NEXT: begin
        if (addr_q == NB_ADDR'(NB_REG - 1)) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  word_serializer #(
    .LEN     (LEN),
    .NB_BYTE (NB_BYTE)
  ) u_word_serializer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (ser_load),
    .i_word  (i_read_data),
    .i_shift (ser_shift),
    .o_byte  (o_tx_data),
    .o_last  (ser_last)
  );

  // The address counter only moves in IDLE and NEXT, so it holds steady through ADDR..CAPT.
  assign o_read_addr = addr_q;
  assign o_tx_start  = (state_q == ST_SEND);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);

endmodule
